// File: rtl/temp.sv
// Single WIDTH-bit holding register: synchronous active-low clear, load on loadTemp, else hold.
// saida is driven straight from the flop, so it only ever moves on a rising clk edge.
module temp #(
  parameter int unsigned            WIDTH       = 16,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loadTemp,
  input  logic [WIDTH-1:0] entrada,
  output logic [WIDTH-1:0] saida
);

  logic [WIDTH-1:0] stored;

  // Reset outranks load, and load outranks hold.
  always_ff @(posedge clk) begin
    if (!reset)        stored <= RESET_VALUE;
    else if (loadTemp) stored <= entrada;
  end

  assign saida = stored;

endmodule

// File: tb/tb_temp.sv
// Self-checking bench for temp: directed vector table, mid-cycle sequences, random vs. reference model.
module tb_temp;
  localparam int W = 16;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         reset;
  logic         loadTemp;
  logic [W-1:0] entrada;
  logic [W-1:0] saida;

  int total = 0;
  int bad   = 0;

  temp #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .loadTemp(loadTemp), .entrada(entrada), .saida(saida)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] din;
    logic [W-1:0] exp;
    string        nm;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: saida=%h expected=%h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; saida sampled there too.
  task automatic step(input logic r, input logic l, input logic [W-1:0] d);
    reset = r; loadTemp = l; entrada = d;
    @(posedge clk); #1;
  endtask

  logic [W-1:0] model;
  logic [W-1:0] held;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, "reset_clear"};
    tbl[1]  = '{1'b1, 1'b1, 16'h5678, 16'h5678, "load_5678"};
    tbl[2]  = '{1'b1, 1'b0, 16'h0001, 16'h5678, "hold_1"};
    tbl[3]  = '{1'b1, 1'b0, 16'h0001, 16'h5678, "hold_2"};
    tbl[4]  = '{1'b1, 1'b0, 16'h0001, 16'h5678, "hold_3"};
    tbl[5]  = '{1'b0, 1'b1, 16'hABCD, 16'h0000, "reset_beats_load"};
    tbl[6]  = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, "release_load_ffff"};
    tbl[7]  = '{1'b1, 1'b1, 16'h8001, 16'h8001, "b2b_8001"};
    tbl[8]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, "b2b_0000"};
    tbl[9]  = '{1'b1, 1'b0, 16'hAAAA, 16'h0000, "hold_zero"};
    tbl[10] = '{1'b1, 1'b1, 16'h7FFF, 16'h7FFF, "load_7fff"};
    tbl[11] = '{1'b0, 1'b0, 16'h5555, 16'h0000, "reset_again"};

    reset = 1'b1; loadTemp = 1'b0; entrada = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].ld, tbl[i].din);
      check(tbl[i].nm, saida, tbl[i].exp);
    end

    // Data toggles mid-cycle: only the value present at the edge is captured.
    step(1'b1, 1'b1, 16'h1111);
    check("mid_pre", saida, 16'h1111);
    entrada = 16'h2222; #2;
    entrada = 16'h3333; #2;
    check("mid_no_change", saida, 16'h1111);
    @(posedge clk); #1;
    check("mid_edge_value", saida, 16'h3333);

    // Reset asserted between edges must wait for the next edge.
    loadTemp = 1'b0; #2;
    reset = 1'b0; #2;
    check("sync_reset_wait", saida, 16'h3333);
    @(posedge clk); #1;
    check("sync_reset_edge", saida, RV);

    // Random traffic against a plain reference model.
    model = RV;
    for (int i = 0; i < 300; i++) begin
      logic r, l;
      logic [W-1:0] d;
      r = ($urandom_range(0, 9) != 0);
      l = $urandom_range(0, 1);
      d = W'($urandom);
      step(r, l, d);
      if (!r)     model = RV;
      else if (l) model = d;
      check("random", saida, model);
      // Wiggle inputs between edges; saida must not move.
      held = saida;
      entrada = W'($urandom); loadTemp = $urandom_range(0, 1); reset = $urandom_range(0, 1);
      #3;
      check("random_midcycle", saida, held);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past limit");
    $fatal(1);
  end

endmodule
